uart_tx_stim: RTL and testbench

Synthesizable UART transmitter for the testbench side of the UART link: it drives the SoC's uart_rx pin with stimulus bytes, the opposite direction to the tty monitor that receives the SoC's uart_tx. Bytes are pushed through a valid/ready port into a small FIFO and serialized as 8N1 (optionally 8E1/8O1) frames at a fixed clock divide. It sits in the test harness between a stimulus source (DPI or script-driven) and `io_uart_rx`.

---
 rtl/uart_tx_stim.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_stim.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stim.sv
// UART transmitter for the stimulus side of the link: valid/ready byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1, sense set by PARITY_ODD).
module uart_tx_stim #(
   parameter int CLK_DIV    = 434,
   parameter int DEPTH      = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   output logic                     txd,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              frames_sent
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(STOP_BITS * CLK_DIV);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * CLK_DIV - 1);
   localparam logic [PW:0]   FULL      = (PW + 1)'(DEPTH);

   if (CLK_DIV < 2 || CLK_DIV > 65535 || DEPTH < 2 || DEPTH > 64 ||
       (DEPTH & (DEPTH - 1)) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
      $error("uart_tx_stim: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic [31:0]      frames_q, frames_d;
   logic [7:0]       mem_q [DEPTH];

   logic             push, pop, frame_done, bit_end;
   logic [7:0]       head;

   assign push    = in_valid && ready_q;
   assign head    = mem_q[rd_ptr_q];
   assign bit_end = (cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      frame_done = 1'b0;
      cnt_d      = bit_end ? cnt_q : cnt_q - CW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
               cnt_d   = BIT_LOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bit_idx_d = '0;
               cnt_d     = BIT_LOAD;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  cnt_d   = BIT_LOAD;
                  state_d = S_PARITY;
`else
                  cnt_d   = STOP_LOAD;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  cnt_d     = BIT_LOAD;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = STOP_LOAD;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               frame_done = 1'b1;
               // Chain straight into the next start bit so queued bytes leave no idle gap.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  cnt_d   = BIT_LOAD;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      txd_d = 1'b1;
      unique case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_d = (^shift_d) ^ (PARITY_ODD != 0);
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PW + 1)'(1);
         2'b01:   count_d = count_q - (PW + 1)'(1);
         default: count_d = count_q;
      endcase
      ready_d  = (count_d != FULL);
      busy_d   = (state_d != S_IDLE) || (count_d != '0);
      frames_d = frame_done ? frames_q + 32'd1 : frames_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         frames_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         frames_q  <= frames_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   assign txd         = txd_q;
   assign busy        = busy_q;
   assign in_ready    = ready_q;
   assign fifo_count  = count_q;
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim at CLK_DIV=4, DEPTH=8, one stop bit; txd sampled on falling edges.
// With UART_TX_PARITY_EN defined the expected frames include an even parity bit.
module tb_uart_tx_stim;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int DIV = 4;
   localparam int FL  = NBITS * DIV;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, txd, busy;
   logic [3:0]  fifo_count;
   logic [31:0] frames_sent;

   int checks = 0;
   int errors = 0;

   uart_tx_stim #(.CLK_DIV(DIV), .DEPTH(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .txd(txd), .busy(busy), .fifo_count(fifo_count),
      .frames_sent(frames_sent)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected txd per cycle: start, data LSB first, optional parity, stop.
   function automatic logic [63:0] exp_wave(input logic [7:0] d);
      logic [10:0] seq;
      logic [63:0] w;
      seq = '0;
      w   = '0;
      seq[8:1] = d;
`ifdef UART_TX_PARITY_EN
      seq[9]  = ^d;
      seq[10] = 1'b1;
`else
      seq[9]  = 1'b1;
`endif
      for (int c = 0; c < FL; c++) w[c] = seq[c / DIV];
      return w;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_txd", txd, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_frames", frames_sent, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic push_one(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // Records txd for one frame; start_idx > 0 means the caller already recorded the first samples.
   task automatic capture(input int max_wait, input int start_idx,
                          inout logic [63:0] wav, output logic [3:0] cnt0);
      int  c;
      bit  found;
      cnt0 = fifo_count;
      c    = start_idx;
      if (start_idx == 0) begin
         found = 1'b0;
         for (int w = 0; w <= max_wait && !found; w++) begin
            @(negedge clock);
            if (txd == 1'b0) found = 1'b1;
         end
         chk("start_found", found, 1);
         wav[0] = txd;
         cnt0   = fifo_count;
         c      = 1;
      end
      for (; c < FL; c++) begin
         @(negedge clock);
         wav[c] = txd;
      end
   endtask

   initial begin
      logic [63:0] wav;
      logic [3:0]  cnt0;
      bit          all_high;

      #2;
      do_reset();

      // Idle after reset
      all_high = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (txd !== 1'b1) all_high = 1'b0;
      end
      chk("idle_txd_high", all_high, 1);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_fifo_count", fifo_count, 0);
      chk("idle_frames", frames_sent, 0);

      // Single byte 0xA5: txd still high after the accepting edge, low after the next
      push_one(8'hA5);
      chk("lat_count", fifo_count, 1);
      chk("lat_txd_high", txd, 1);
      wav = '0;
      capture(0, 0, wav, cnt0);
      chk("a5_popped", cnt0, 0);
      chk("a5_frame", wav, exp_wave(8'hA5));
      chk("a5_busy_in_stop", busy, 1);
      chk("a5_frames_before", frames_sent, 0);
      @(negedge clock);
      chk("a5_busy_after", busy, 0);
      chk("a5_frames_after", frames_sent, 1);
      chk("a5_txd_after", txd, 1);

      // Back-to-back bytes
      do_reset();
      wav = '0;
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clock);
      chk("b2b_count_e1", fifo_count, 1);
      in_data = 8'hFF;
      @(negedge clock);
      chk("b2b_count_e2", fifo_count, 1);
      wav[0] = txd;
      in_data = 8'h55;
      @(negedge clock);
      chk("b2b_count_e3", fifo_count, 2);
      wav[1] = txd;
      in_valid = 1'b0;
      capture(0, 2, wav, cnt0);
      chk("b2b_frame_00", wav, exp_wave(8'h00));
      chk("b2b_count_end0", fifo_count, 2);
      wav = '0;
      capture(0, 0, wav, cnt0);
      chk("b2b_count_start1", cnt0, 1);
      chk("b2b_frame_ff", wav, exp_wave(8'hFF));
      wav = '0;
      capture(0, 0, wav, cnt0);
      chk("b2b_count_start2", cnt0, 0);
      chk("b2b_frame_55", wav, exp_wave(8'h55));
      @(negedge clock);
      chk("b2b_frames", frames_sent, 3);
      chk("b2b_busy_after", busy, 0);

      // Full FIFO while a frame is on the line
      do_reset();
      push_one(8'h11);
      @(negedge clock);
      chk("full_frame_started", txd, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_data = 8'h20 + 8'(i);
         @(negedge clock);
         chk("full_count", fifo_count, (i + 1 < 8) ? i + 1 : 8);
         chk("full_in_ready", in_ready, (i + 1 < 8) ? 1 : 0);
      end
      in_valid = 1'b0;
      repeat (FL - 13) @(negedge clock);
      chk("full_count_last", fifo_count, 8);
      chk("full_ready_last", in_ready, 0);
      @(negedge clock);
      chk("full_ready_back", in_ready, 1);
      chk("full_count_pop", fifo_count, 7);
      wav = '0;
      wav[0] = txd;
      capture(0, 1, wav, cnt0);
      chk("full_frame_20", wav, exp_wave(8'h20));
      for (int k = 1; k < 8; k++) begin
         wav = '0;
         capture(0, 0, wav, cnt0);
         chk("full_frame_seq", wav, exp_wave(8'h20 + 8'(k)));
      end
      @(negedge clock);
      chk("full_busy_end", busy, 0);
      chk("full_count_end", fifo_count, 0);
      chk("full_frames", frames_sent, 9);
      all_high = 1'b1;
      for (int i = 0; i < 3 * FL; i++) begin
         @(negedge clock);
         if (txd !== 1'b1) all_high = 1'b0;
      end
      chk("full_no_dropped_bytes", all_high, 1);

`ifdef UART_TX_PARITY_EN
      // Even parity on 0x07 (three ones -> parity bit 1)
      push_one(8'h07);
      wav = '0;
      capture(0, 0, wav, cnt0);
      chk("par_frame_07", wav, exp_wave(8'h07));
      chk("par_bit", wav[9 * DIV + 2], 1);
`endif

      // Reset during data bit 3 of 0x3C with another byte queued
      do_reset();
      push_one(8'h3C);
      push_one(8'h99);
      repeat (17) @(negedge clock);
      chk("midrst_pre_txd", txd, 1);
      chk("midrst_pre_count", fifo_count, 1);
      chk("midrst_pre_busy", busy, 1);
      do_reset();
      push_one(8'h81);
      wav = '0;
      capture(0, 0, wav, cnt0);
      chk("midrst_frame_81", wav, exp_wave(8'h81));
      @(negedge clock);
      chk("midrst_frames", frames_sent, 1);

      // Reset during a start bit must raise txd without waiting for a clock edge
      push_one(8'h42);
      @(negedge clock);
      chk("startrst_pre_txd", txd, 0);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
